vga_scanout: RTL and testbench

- Read side of the 320x240x3-bit frame buffer that the game datapath writes as (x, y, colour).
- Generates 640x480@60 VGA timing from the 50 MHz system clock.
- Issues read addresses so each buffer pixel is shown as a 2x2 block.
- Drives sync, blank and 8-bit-per-channel RGB to the DAC.

---
 rtl/vga_scanout.sv | 161 ++++++++++++++++
 tb/tb_vga_scanout.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scanout.sv
// ---------------------------------------------------------------------------
// vga_scanout
//
// Read side of the 320x240x3-bit frame buffer. Generates 640x480@60 VGA
// timing from the 50 MHz system clock and fetches frame buffer pixels so
// that each stored pixel covers a 2x2 block on screen.
//
// Ports:
//   clk          in   system clock (50 MHz)
//   resetn       in   synchronous active-low reset
//   rd_addr      out  [16:0] frame buffer read address (combinational)
//   rd_data      in   [2:0]  colour {R,G,B}, valid 1 clk after rd_addr
//   vga_hs       out  horizontal sync, active low
//   vga_vs       out  vertical sync, active low
//   vga_blank_n  out  high while in the visible area
//   vga_r/g/b    out  [7:0] colour channels to the DAC
//   frame_start  out  one-clk pulse when the scan wraps to (0,0)
//   pix_tick     out  pixel-enable strobe, one clk per pixel period
//
// The output stage registers on pix_tick, so sync/blank/colour lag the
// counters by exactly one pixel tick. That lag is what gives the RAM its
// read cycle: rd_addr settles right after a tick, rd_data is valid one clk
// later, and the next tick (at least two clks away) samples it.
// ---------------------------------------------------------------------------
module vga_scanout #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int FB_W     = 320
) (
    input  logic        clk,
    input  logic        resetn,
    output logic [16:0] rd_addr,
    input  logic [2:0]  rd_data,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        frame_start,
    output logic        pix_tick
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = $clog2(CLK_DIV);
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

    // Off-screen coordinates are clamped to the last buffer column/row so
    // the address never leaves the buffer.
    localparam logic [16:0] X_CLAMP   = 17'(FB_W - 1);
    localparam logic [16:0] Y_CLAMP   = 17'(V_ACTIVE / 2 - 1);
    localparam logic [16:0] FB_STRIDE = 17'(FB_W);

    logic [DW-1:0] div;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          h_wrap;
    logic          v_wrap;
    logic          active;
    logic          hs_pulse;
    logic          vs_pulse;
    logic [16:0]   x_pix;
    logic [16:0]   y_pix;

    assign pix_tick = (div == DIV_LAST);
    assign h_wrap   = (h_cnt == H_LAST);
    assign v_wrap   = (v_cnt == V_LAST);
    assign active   = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign hs_pulse = (h_cnt >= HS_START) && (h_cnt < HS_END);
    assign vs_pulse = (v_cnt >= VS_START) && (v_cnt < VS_END);

    // Clock divider: one pixel tick every CLK_DIV system clocks.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            div <= '0;
        end else if (pix_tick) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    // Raster position; the line counter steps when the pixel counter wraps.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_tick) begin
            if (h_wrap) begin
                h_cnt <= '0;
                v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    // Halving both coordinates makes each buffer pixel a 2x2 screen block.
    always_comb begin
        x_pix = 17'(h_cnt >> 1);
        y_pix = 17'(v_cnt >> 1);
        if (h_cnt >= H_ACT) begin
            x_pix = X_CLAMP;
        end
        if (v_cnt >= V_ACT) begin
            y_pix = Y_CLAMP;
        end
    end

    assign rd_addr = y_pix * FB_STRIDE + x_pix;

    // Output stage: samples the position held since the previous tick
    // together with the pixel fetched for it.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank_n <= 1'b0;
            vga_r       <= 8'h00;
            vga_g       <= 8'h00;
            vga_b       <= 8'h00;
        end else if (pix_tick) begin
            vga_hs      <= ~hs_pulse;
            vga_vs      <= ~vs_pulse;
            vga_blank_n <= active;
            vga_r       <= (active && rd_data[2]) ? 8'hFF : 8'h00;
            vga_g       <= (active && rd_data[1]) ? 8'hFF : 8'h00;
            vga_b       <= (active && rd_data[0]) ? 8'hFF : 8'h00;
        end
    end

    // Frame pulse is high for the single clk in which the counters have
    // just wrapped to (0,0); a reset start never produces it.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= pix_tick && h_wrap && v_wrap;
        end
    end

endmodule

// File: tb/tb_vga_scanout.sv
// ---------------------------------------------------------------------------
// tb_vga_scanout
//
// Drives two instances: one with the full 640x480 timing (line timing,
// addressing, mid-frame reset) and one with a tiny raster and CLK_DIV=3 so
// whole frames, vsync and frame wrap fit in a short run. A frame buffer model
// per instance answers reads one clk late. The expected outputs are derived
// from the number of clk edges since reset: pixel ticks = edges / CLK_DIV,
// raster position = ticks modulo the frame size, outputs show the previous
// tick's position.
// ---------------------------------------------------------------------------
module tb_vga_scanout;

    // Small raster used by instance B
    localparam int B_DIV = 3;
    localparam int B_HA = 16, B_HF = 2, B_HS = 4, B_HB = 2;
    localparam int B_VA = 8,  B_VF = 1, B_VS = 2, B_VB = 2;
    localparam int B_FBW = 8;

    logic        clk = 1'b0;
    logic        resetn_a, resetn_b;
    logic [16:0] rd_addr_a, rd_addr_b;
    logic [2:0]  rd_data_a, rd_data_b;
    logic        hs_a, vs_a, blank_a, fs_a, tick_a;
    logic        hs_b, vs_b, blank_b, fs_b, tick_b;
    logic [7:0]  r_a, g_a, b_a, r_b, g_b, b_b;

    int  checks = 0;
    int  failures = 0;
    int  e_a = 0, e_b = 0;
    bit  valid_a = 0, valid_b = 0;
    int  mode_a = 0, mode_b = 0;
    int  fs_count_b = 0;

    always #10 clk = ~clk;

    vga_scanout dut_a (
        .clk(clk), .resetn(resetn_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
        .vga_hs(hs_a), .vga_vs(vs_a), .vga_blank_n(blank_a),
        .vga_r(r_a), .vga_g(g_a), .vga_b(b_a),
        .frame_start(fs_a), .pix_tick(tick_a)
    );

    vga_scanout #(
        .CLK_DIV(B_DIV), .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
        .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB), .FB_W(B_FBW)
    ) dut_b (
        .clk(clk), .resetn(resetn_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
        .vga_hs(hs_b), .vga_vs(vs_b), .vga_blank_n(blank_b),
        .vga_r(r_b), .vga_g(g_b), .vga_b(b_b),
        .frame_start(fs_b), .pix_tick(tick_b)
    );

    // Frame buffer contents: mode 1 is all white, otherwise a scrambled
    // pattern with a fixed magenta pixel at address 321.
    function automatic logic [2:0] ramData(input int addr, input int mode);
        if (mode == 1) return 3'b111;
        if (addr == 321) return 3'b101;
        return 3'((addr * 5 + addr / 9) % 8);
    endfunction

    always @(posedge clk) begin
        rd_data_a <= ramData(int'(rd_addr_a), mode_a);
        rd_data_b <= ramData(int'(rd_addr_b), mode_b);
    end

    // Edge counters since the last clk edge that sampled reset.
    always @(posedge clk) begin
        e_a <= resetn_a ? e_a + 1 : 0;
        e_b <= resetn_b ? e_b + 1 : 0;
        if (!resetn_a) valid_a <= 1'b1;
        if (!resetn_b) valid_b <= 1'b1;
    end

    function automatic logic [16:0] pixAddr(input int h, input int v, input int ha,
                                            input int va, input int fbw);
        int x, y;
        x = (h < ha) ? h / 2 : fbw - 1;
        y = (v < va) ? v / 2 : va / 2 - 1;
        return 17'(y * fbw + x);
    endfunction

    // Expected {rd_addr, pix_tick, hs, vs, blank_n, r, g, b, frame_start}
    function automatic logic [45:0] modelOut(input int e, input int d,
        input int ha, input int hf, input int hsy, input int hb,
        input int va, input int vf, input int vsy, input int vb,
        input int fbw, input int mode);
        int ht, vt, ft, t, p, q, hq, vq;
        logic [16:0] addr;
        logic        ptk, hso, vso, act, fso;
        logic [2:0]  col;
        logic [7:0]  r, g, b;
        ht = ha + hf + hsy + hb;
        vt = va + vf + vsy + vb;
        ft = ht * vt;
        t  = e / d;
        p  = t % ft;
        addr = pixAddr(p % ht, p / ht, ha, va, fbw);
        ptk  = ((e % d) == d - 1);
        fso  = ((e % d) == 0) && (t > 0) && (p == 0);
        hso = 1'b1; vso = 1'b1; act = 1'b0; r = 8'h00; g = 8'h00; b = 8'h00;
        if (t > 0) begin
            q   = (t - 1) % ft;
            hq  = q % ht;
            vq  = q / ht;
            act = (hq < ha) && (vq < va);
            hso = !((hq >= ha + hf) && (hq < ha + hf + hsy));
            vso = !((vq >= va + vf) && (vq < va + vf + vsy));
            col = ramData(int'(pixAddr(hq, vq, ha, va, fbw)), mode);
            r = (act && col[2]) ? 8'hFF : 8'h00;
            g = (act && col[1]) ? 8'hFF : 8'h00;
            b = (act && col[0]) ? 8'hFF : 8'h00;
        end
        return {addr, ptk, hso, vso, act, r, g, b, fso};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h (e_a=%0d e_b=%0d)",
                     name, act, exp, e_a, e_b);
        end
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (valid_a)
            checkOutput("A_cycle",
                {rd_addr_a, tick_a, hs_a, vs_a, blank_a, r_a, g_a, b_a, fs_a},
                modelOut(e_a, 2, 640, 16, 96, 48, 480, 10, 2, 33, 320, mode_a));
        if (valid_b)
            checkOutput("B_cycle",
                {rd_addr_b, tick_b, hs_b, vs_b, blank_b, r_b, g_b, b_b, fs_b},
                modelOut(e_b, B_DIV, B_HA, B_HF, B_HS, B_HB, B_VA, B_VF, B_VS, B_VB,
                         B_FBW, mode_b));
        if (valid_b && fs_b) fs_count_b++;
    end

    function automatic logic [31:0] getSig(input bit is_b, input int sig);
        case (sig)
            0: return 32'(is_b ? rd_addr_b : rd_addr_a);
            1: return 32'(is_b ? tick_b : tick_a);
            2: return 32'(is_b ? hs_b : hs_a);
            3: return 32'(is_b ? vs_b : vs_a);
            4: return 32'(is_b ? blank_b : blank_a);
            5: return 32'(is_b ? r_b : r_a);
            6: return 32'(is_b ? g_b : g_a);
            7: return 32'(is_b ? b_b : b_a);
            8: return 32'(is_b ? fs_b : fs_a);
            default: return 32'(is_b ? fs_count_b : 0);
        endcase
    endfunction

    // Wait (on falling edges) until the chosen instance's edge count hits target.
    task automatic waitEdges(input bit is_b, input int target);
        int n = 0;
        while (((is_b ? e_b : e_a) != target) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) begin
            checks++;
            failures++;
            $display("[TB] FAIL timeout waiting for edge %0d", target);
        end
    endtask

    task automatic lit(input bit is_b, input int e, input string name, input int sig,
                       input logic [31:0] exp);
        waitEdges(is_b, e);
        checkOutput(name, 64'(getSig(is_b, sig)), 64'(exp));
    endtask

    // One-clk (or longer) reset pulse; the new frame buffer mode takes
    // effect after the reset edge so no in-flight read sees it.
    task automatic applyStimulus(input bit is_b, input int clks, input int mode);
        if (is_b) resetn_b = 1'b0; else resetn_a = 1'b0;
        repeat (clks) @(posedge clk);
        #1;
        if (is_b) mode_b = mode; else mode_a = mode;
        @(negedge clk);
        if (is_b) resetn_b = 1'b1; else resetn_a = 1'b1;
    endtask

    task automatic runA();
        lit(0, 1,    "A_first_tick",     1, 1);
        lit(0, 1,    "A_blank_pre",      4, 0);
        lit(0, 2,    "A_blank_first",    4, 1);
        lit(0, 1280, "A_blank_h639",     4, 1);
        lit(0, 1282, "A_blank_h640",     4, 0);
        lit(0, 1312, "A_hs_h655",        2, 1);
        lit(0, 1314, "A_hs_h656",        2, 0);
        lit(0, 1504, "A_hs_h751",        2, 0);
        lit(0, 1506, "A_hs_h752",        2, 1);
        lit(0, 4804, "A_addr_h2_v3",     0, 321);
        lit(0, 4806, "A_r_321",          5, 32'hFF);
        lit(0, 4806, "A_g_321",          6, 32'h00);
        lit(0, 4806, "A_b_321",          7, 32'hFF);
        lit(0, 7800, "A_addr_clamp",     0, 959);
        waitEdges(0, 10200);
        applyStimulus(0, 1, 0);
        lit(0, 0,    "A_rst_hs",         2, 1);
        lit(0, 0,    "A_rst_addr",       0, 0);
        lit(0, 1,    "A_rst_tick",       1, 1);
        lit(0, 2,    "A_rst_blank",      4, 1);
        waitEdges(0, 3000);
    endtask

    task automatic runB();
        lit(1, 549,  "B_addr_max",       0, 31);
        lit(1, 648,  "B_vs_v8",          3, 1);
        lit(1, 651,  "B_vs_v9",          3, 0);
        lit(1, 935,  "B_fs_before",      8, 0);
        lit(1, 936,  "B_fs_wrap",        8, 1);
        lit(1, 939,  "B_fs_after",       8, 0);
        lit(1, 939,  "B_fs_count",       9, 1);
        waitEdges(1, 2262);
        applyStimulus(1, 1, 1);
        lit(1, 2,    "B_rst_tick",       1, 1);
        lit(1, 3,    "B_white_r",        5, 32'hFF);
        lit(1, 51,   "B_blank_r",        5, 32'h00);
        lit(1, 51,   "B_blank_n",        4, 0);
        waitEdges(1, 3000);
    endtask

    initial begin
        resetn_a = 1'b0;
        resetn_b = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkOutput("A_reset_hs",    64'(hs_a), 64'd1);
        checkOutput("A_reset_vs",    64'(vs_a), 64'd1);
        checkOutput("A_reset_blank", 64'(blank_a), 64'd0);
        checkOutput("A_reset_rgb",   64'({r_a, g_a, b_a}), 64'd0);
        checkOutput("A_reset_addr",  64'(rd_addr_a), 64'd0);
        checkOutput("A_reset_tick",  64'(tick_a), 64'd0);
        resetn_a = 1'b1;
        resetn_b = 1'b1;
        fork
            runA();
            runB();
        join
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
